// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage MIPS core.
// Merges stall requests from IF/ID/EX/MEM and the exception status of the
// MEM-stage instruction into the stall vector, flush strobe and redirect PC.
// An exception raised while MEM has a bus transaction in flight is parked in
// DRAIN until the bus goes idle. A watchdog flags a pipeline that has been
// stalled for too long.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush
// performance counters; without it both counter outputs are tied to zero.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   stallreq_*_i   stall requests from IF, ID, EX, MEM
//   mem_busy_i     MEM has an uncancellable bus transaction outstanding
//   excepttype_i   exception code of the MEM-stage instruction (0 = none)
//   cp0_epc_i      EPC used as the ERET target
//   stall          per-stage stop vector (bit0 PC .. bit5 WB), combinational
//   flush          flush all latches to NOP, combinational
//   new_pc         redirect target, nonzero only while flush = 1
//   stall_err_o    sticky watchdog flag
//   stall_cnt_o    total stalled cycles (perf build only)
//   flush_cnt_o    total flush cycles (perf build only)
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        mem_busy_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned WD_W     = 16;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_exc;
  logic [31:0]     r_epc;
  logic            w_latch;
  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_nxt;
  logic            r_stall_err;

  // Handler address for a given exception code.
  function automatic logic [31:0] f_target(input logic [31:0] code,
                                           input logic [31:0] epc);
    if (code == EXC_INT)       f_target = INT_VECTOR;
    else if (code == EXC_ERET) f_target = epc;
    else                       f_target = EXC_VECTOR;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // Next state and combinational pipeline controls.
  always_comb begin
    w_state_nxt = r_state;
    stall       = STALL_NONE;
    flush       = 1'b0;
    new_pc      = 32'h0;
    w_latch     = 1'b0;
    case (r_state)
      ST_DRAIN: begin
        // Live exceptions are ignored until the parked one is delivered.
        if (mem_busy_i) begin
          stall = STALL_MEM;
        end else begin
          flush       = 1'b1;
          new_pc      = f_target(r_exc, r_epc);
          w_state_nxt = ST_REDIRECT;
        end
      end
      ST_RUN, ST_REDIRECT: begin
        w_state_nxt = ST_RUN;
        if (excepttype_i != 32'h0) begin
          if (mem_busy_i) begin
            w_latch     = 1'b1;
            stall       = STALL_MEM;
            w_state_nxt = ST_DRAIN;
          end else begin
            flush       = 1'b1;
            new_pc      = f_target(excepttype_i, cp0_epc_i);
            w_state_nxt = ST_REDIRECT;
          end
        end else if (stallreq_mem_i) begin
          stall = STALL_MEM;
        // ID/EX requests right after a flush come from squashed instructions.
        end else if (stallreq_ex_i && (r_state != ST_REDIRECT)) begin
          stall = STALL_EX;
        end else if (stallreq_id_i && (r_state != ST_REDIRECT)) begin
          stall = STALL_ID;
        end else if (stallreq_if_i) begin
          stall = STALL_IF;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Parked exception code and EPC for DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc <= 32'h0;
      r_epc <= 32'h0;
    end else if (w_latch) begin
      r_exc <= excepttype_i;
      r_epc <= cp0_epc_i;
    end
  end

  // Watchdog: consecutive stalled cycles, saturating at the limit.
  always_comb begin
    w_wd_nxt = '0;
    if (stall != STALL_NONE) begin
      if (r_wd_cnt == WD_LIMIT) w_wd_nxt = WD_LIMIT;
      else                      w_wd_nxt = r_wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt    <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      if (w_wd_nxt == WD_LIMIT) r_stall_err <= 1'b1;
    end
  end

  assign stall_err_o = r_stall_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running performance counters, wrap modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (stall != STALL_NONE) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)               r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = 32'h0;
  assign flush_cnt_o = 32'h0;
`endif

endmodule
